tmds_link_ctrl: RTL and testbench
=================================

TMDS_LINK_CTRL -- requirements
Module: tmds_link_ctrl

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 8, meaning consecutive i_pll_locked-high cycles required before link bring-up (range 1-255).
REQ-002 SHALL have parameter RST_CYCLES, default 16, meaning the number of cycles o_rst_oserdes is held in SERDES_RST (range 2-255).
REQ-003 SHALL have parameter WARMUP_CYCLES, default 64, meaning the number of control-token cycles sent before ACTIVE (range 1-1023).
REQ-004 SHALL have i_clk  input  1  pixel (parallel) clock; the only clock.
REQ-005 SHALL have i_rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have i_pll_locked  input  1  clock-generator lock, already synchronous to i_clk.
REQ-007 SHALL have i_enable  input  1  link enable request.
REQ-008 SHALL have i_tmds  input  30  encoded words: [9:0] ch0, [19:10] ch1, [29:20] ch2.
REQ-009 SHALL have o_rst_oserdes  output  1  active-high serializer reset.
REQ-010 SHALL have o_tmds  output  30  words to the three 10:1 serializers, same lane packing as i_tmds.
REQ-011 SHALL have o_link_up  output  1  high only in ACTIVE.
REQ-012 SHALL have o_state  output  2  current state encoding.
REQ-013 SHALL have o_relock_count  output  8  saturating count of lock losses from ACTIVE.

Function
REQ-014 SHALL implement states RESET=2'b00, SERDES_RST=2'b01, WARMUP=2'b10, ACTIVE=2'b11, reported on o_state.
REQ-015 SHALL register all outputs; each output value at edge k reflects the state entered at edge k.
REQ-016 SHALL keep a lock filter counter that increments while i_pll_locked=1, saturates at LOCK_FILTER, and clears to 0 on any cycle with i_pll_locked=0.
REQ-017 SHALL go RESET->SERDES_RST on the edge where i_enable=1 and i_pll_locked has been sampled high for LOCK_FILTER consecutive edges, including this one.
REQ-018 SHALL remain in SERDES_RST for exactly RST_CYCLES edges, then go to WARMUP.
REQ-019 SHALL remain in WARMUP for exactly WARMUP_CYCLES edges, then go to ACTIVE.
REQ-020 SHALL assert o_rst_oserdes=1 in RESET and SERDES_RST, and 0 in WARMUP and ACTIVE.
REQ-021 SHALL drive o_tmds={3{10'b1101010100}} (control token C1C0=00) in RESET, SERDES_RST and WARMUP.
REQ-022 SHALL, in ACTIVE, drive o_tmds equal to i_tmds sampled at the same edge (1-cycle latency, no modification).
REQ-023 SHALL go to RESET from any state on an edge sampling i_pll_locked=0 or i_enable=0; this abort has priority over all other transitions, including a terminal count.
REQ-024 SHALL increment o_relock_count (saturating at 255) only on an ACTIVE->RESET transition where i_pll_locked=0; an i_enable=0-only exit SHALL NOT count, and simultaneous loss of lock and enable SHALL count once.
REQ-025 SHALL restart the full sequence (filter, SERDES_RST, WARMUP) after any return to RESET; SHALL NOT retain partial counts.
REQ-026 SHALL size the internal cycle counter to $clog2 of the maximum of RST_CYCLES and WARMUP_CYCLES plus 1, and SHALL reload it to 0 on every state change.

Reset
REQ-027 SHALL, on an edge with i_rst_n=0, set state=RESET, o_rst_oserdes=1, o_tmds={3{10'b1101010100}}, o_link_up=0, o_state=2'b00, o_relock_count=0, and all counters to 0.
REQ-028 SHALL give i_rst_n=0 mid-sequence (any state) priority over all other inputs, with identical results to REQ-027.

Verification (LOCK_FILTER=4, RST_CYCLES=4, WARMUP_CYCLES=8)
REQ-029 SHALL cover bring-up: lock=1 and enable=1 from edge 1 -> o_state=01 at edge 4, 10 at edge 8 (o_rst_oserdes falls), 11 at edge 16 (o_link_up=1).
REQ-030 SHALL cover data path: in ACTIVE, drive i_tmds=30'h2AA_5555 at edge n -> o_tmds=30'h2AA_5555 at edge n; at edge n-1, o_tmds equals the word driven at edge n-1.
REQ-031 SHALL cover lock glitch: lock high for 3 edges, low 1, then high -> no SERDES_RST until 4 further consecutive high edges.
REQ-032 SHALL cover lock loss in ACTIVE: lock=0 for 1 edge -> o_state=00, o_rst_oserdes=1, o_link_up=0, o_relock_count 0->1; re-bring-up then takes 16 edges again.
REQ-033 SHALL cover enable drop in WARMUP at its final cycle -> RESET and no ACTIVE entry; a 256th counted lock loss leaves o_relock_count=255.
REQ-034 SHALL cover i_rst_n=0 in ACTIVE with o_relock_count=3 -> every output returns to the REQ-027 values at that edge.

Source files
------------

// File: rtl/tmds_link_ctrl.sv
// TMDS link bring-up sequencer: lock filter, serializer reset, control-token warmup, then data pass-through.
// Latency: all outputs registered; in ACTIVE o_tmds is i_tmds delayed by one cycle.
// Backpressure: none; free-running pixel stream, any lock/enable loss aborts to RESET.
module tmds_link_ctrl #(
    parameter int LOCK_FILTER   = 8,
    parameter int RST_CYCLES    = 16,
    parameter int WARMUP_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pll_locked,
    input  logic        i_enable,
    input  logic [29:0] i_tmds,
    output logic        o_rst_oserdes,
    output logic [29:0] o_tmds,
    output logic        o_link_up,
    output logic [1:0]  o_state,
    output logic [7:0]  o_relock_count
);

    localparam int CNT_MAX = (RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP_CYCLES - 1);
    localparam logic [7:0]    LF_MAX     = 8'(LOCK_FILTER);
    localparam logic [7:0]    LF_LAST    = 8'(LOCK_FILTER - 1);
    localparam logic [29:0]   CTRL_TOKEN = {3{10'b1101010100}};

    typedef enum logic [1:0] {
        ST_RESET      = 2'b00,
        ST_SERDES_RST = 2'b01,
        ST_WARMUP     = 2'b10,
        ST_ACTIVE     = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [7:0]    lock_cnt, lock_nxt;
    logic          lock_ok;
    logic          relock_inc;

    always_comb begin
        state_nxt  = state;
        relock_inc = 1'b0;
        lock_nxt   = '0;
        if (i_pll_locked)
            lock_nxt = (lock_cnt == LF_MAX) ? LF_MAX : lock_cnt + 8'd1;
        // lock_cnt holds prior consecutive highs, so this edge completes the window
        lock_ok = i_pll_locked && (lock_cnt >= LF_LAST);

        if (!i_pll_locked || !i_enable) begin
            state_nxt  = ST_RESET;
            relock_inc = (state == ST_ACTIVE) && !i_pll_locked;
        end else begin
            case (state)
                ST_RESET:      if (lock_ok)               state_nxt = ST_SERDES_RST;
                ST_SERDES_RST: if (cyc_cnt == RST_LAST)   state_nxt = ST_WARMUP;
                ST_WARMUP:     if (cyc_cnt == WARM_LAST)  state_nxt = ST_ACTIVE;
                ST_ACTIVE:                                state_nxt = ST_ACTIVE;
            endcase
        end

        if (state_nxt != state || state == ST_RESET || state == ST_ACTIVE)
            cyc_nxt = '0;
        else
            cyc_nxt = cyc_cnt + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= ST_RESET;
            cyc_cnt        <= '0;
            lock_cnt       <= '0;
            o_relock_count <= '0;
            o_rst_oserdes  <= 1'b1;
            o_tmds         <= CTRL_TOKEN;
            o_link_up      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc_cnt  <= cyc_nxt;
            lock_cnt <= lock_nxt;
            if (relock_inc && o_relock_count != 8'hFF)
                o_relock_count <= o_relock_count + 8'd1;
            o_rst_oserdes <= (state_nxt == ST_RESET) || (state_nxt == ST_SERDES_RST);
            o_tmds        <= (state_nxt == ST_ACTIVE) ? i_tmds : CTRL_TOKEN;
            o_link_up     <= (state_nxt == ST_ACTIVE);
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Bench for tmds_link_ctrl: directed scenarios plus random lock/enable/reset traffic against a reference model.
module tb_tmds_link_ctrl;

    localparam int LF = 4;
    localparam int RC = 4;
    localparam int WC = 8;
    localparam logic [29:0] TOK = {3{10'b1101010100}};
    localparam logic [41:0] RST_VEC = {2'b00, 1'b1, 1'b0, 8'd0, TOK};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;
    logic        en = 1'b0;
    logic [29:0] din = '0;
    logic        o_rst_oserdes;
    logic [29:0] o_tmds;
    logic        o_link_up;
    logic [1:0]  o_state;
    logic [7:0]  o_relock_count;

    always #5 clk = ~clk;

    tmds_link_ctrl #(.LOCK_FILTER(LF), .RST_CYCLES(RC), .WARMUP_CYCLES(WC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pll_locked(lock), .i_enable(en), .i_tmds(din),
        .o_rst_oserdes(o_rst_oserdes), .o_tmds(o_tmds), .o_link_up(o_link_up),
        .o_state(o_state), .o_relock_count(o_relock_count)
    );

    wire [41:0] act = {o_state, o_rst_oserdes, o_link_up, o_relock_count, o_tmds};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state held as 0..3, time in state measured as edge-number difference
    int          m_st = 0;
    int          m_run = 0;
    int          m_edge = 0;
    int          m_entry = 0;
    int          m_relock = 0;
    logic [29:0] m_din = '0;

    function automatic logic [41:0] exp_vec();
        logic [1:0] s;
        logic [7:0] r;
        s = 2'(m_st);
        r = 8'(m_relock);
        return {s, (m_st < 2), (m_st == 3), r, (m_st == 3) ? m_din : TOK};
    endfunction

    task automatic tick(input logic r, input logic l, input logic e, input logic [29:0] d);
        int nst;
        rst_n = r; lock = l; en = e; din = d;
        @(posedge clk);
        m_edge++;
        if (!r) begin
            m_st = 0; m_run = 0; m_relock = 0; m_entry = m_edge;
        end else begin
            nst = m_st;
            m_run = l ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            if (!l || !e) begin
                nst = 0;
                if (m_st == 3 && !l && m_relock < 255) m_relock++;
            end else if (m_st == 0 && m_run >= LF) nst = 1;
            else if (m_st == 1 && m_edge - m_entry == RC) nst = 2;
            else if (m_st == 2 && m_edge - m_entry == WC) nst = 3;
            if (nst != m_st) m_entry = m_edge;
            m_st = nst;
        end
        m_din = d;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 30'($urandom));
            n_cmp++;
            if (act !== RST_VEC) begin
                n_bad++;
                $display("FAIL reset_state cyc%0d: got %h want %h", i, act, RST_VEC);
            end
        end
    endtask

    task automatic test_bringup();
        logic [1:0] es;
        tick(1'b0, 1'b0, 1'b0, '0);
        for (int e = 1; e <= 16; e++) begin
            tick(1'b1, 1'b1, 1'b1, 30'($urandom));
            es = (e < 4) ? 2'b00 : (e < 8) ? 2'b01 : (e < 16) ? 2'b10 : 2'b11;
            n_cmp++;
            if (o_state !== es || o_rst_oserdes !== (e < 8) || o_link_up !== (e == 16)) begin
                n_bad++;
                $display("FAIL bringup edge%0d: got st=%b rst=%b up=%b want st=%b", e, o_state,
                         o_rst_oserdes, o_link_up, es);
            end
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL bringup_model edge%0d: got %h want %h", e, act, exp_vec());
            end
        end
    endtask

    task automatic test_datapath();
        logic [29:0] d;
        for (int i = 0; i < 20; i++) begin
            d = (i == 5) ? 30'h2AA_5555 : 30'($urandom);
            tick(1'b1, 1'b1, 1'b1, d);
            n_cmp++;
            if (o_tmds !== d || o_link_up !== 1'b1) begin
                n_bad++;
                $display("FAIL datapath word%0d: got %h up=%b want %h", i, o_tmds, o_link_up, d);
            end
        end
    endtask

    task automatic test_lock_glitch();
        logic l;
        tick(1'b0, 1'b0, 1'b1, '0);
        for (int e = 1; e <= 8; e++) begin
            l = (e != 4);
            tick(1'b1, l, 1'b1, 30'($urandom));
            n_cmp++;
            if (o_state !== ((e == 8) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL lock_glitch edge%0d: got st=%b want %b", e, o_state,
                         (e == 8) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_lock_loss();
        tick(1'b0, 1'b0, 1'b1, '0);
        for (int e = 1; e <= 16; e++) tick(1'b1, 1'b1, 1'b1, 30'($urandom));
        tick(1'b1, 1'b0, 1'b1, 30'($urandom));
        n_cmp++;
        if ({o_state, o_rst_oserdes, o_link_up, o_relock_count} !== {2'b00, 1'b1, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL lock_loss: got st=%b rst=%b up=%b cnt=%0d want 00/1/0/1", o_state,
                     o_rst_oserdes, o_link_up, o_relock_count);
        end
        for (int e = 1; e <= 16; e++) begin
            tick(1'b1, 1'b1, 1'b1, 30'($urandom));
            n_cmp++;
            if (o_link_up !== (e == 16) || act !== exp_vec()) begin
                n_bad++;
                $display("FAIL relock_bringup edge%0d: got %h want %h", e, act, exp_vec());
            end
        end
    endtask

    task automatic test_enable_drop();
        tick(1'b0, 1'b0, 1'b1, '0);
        for (int e = 1; e <= 15; e++) tick(1'b1, 1'b1, 1'b1, 30'($urandom));
        n_cmp++;
        if (o_state !== 2'b10) begin
            n_bad++;
            $display("FAIL en_drop_pre: got st=%b want 10", o_state);
        end
        for (int e = 0; e < 4; e++) begin
            tick(1'b1, 1'b1, 1'b0, 30'($urandom));
            n_cmp++;
            if (act !== RST_VEC) begin
                n_bad++;
                $display("FAIL en_drop cyc%0d: got %h want %h", e, act, RST_VEC);
            end
        end
    endtask

    task automatic test_relock_sat();
        tick(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 256; i++) begin
            for (int e = 0; e < 16; e++) tick(1'b1, 1'b1, 1'b1, 30'($urandom));
            tick(1'b1, 1'b0, ($urandom_range(0, 1) == 1), 30'($urandom));
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL relock_count loss%0d: got %h want %h", i + 1, act, exp_vec());
            end
            if (i >= 254) begin
                n_cmp++;
                if (o_relock_count !== 8'd255) begin
                    n_bad++;
                    $display("FAIL relock_sat loss%0d: got %0d want 255", i + 1, o_relock_count);
                end
            end
        end
    endtask

    task automatic test_rst_in_active();
        tick(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < 16; e++) tick(1'b1, 1'b1, 1'b1, 30'($urandom));
            tick(1'b1, 1'b0, 1'b1, '0);
        end
        for (int e = 0; e < 16; e++) tick(1'b1, 1'b1, 1'b1, 30'($urandom));
        n_cmp++;
        if (o_link_up !== 1'b1 || o_relock_count !== 8'd3) begin
            n_bad++;
            $display("FAIL rst_active_pre: got up=%b cnt=%0d want 1/3", o_link_up, o_relock_count);
        end
        tick(1'b0, 1'b1, 1'b1, 30'($urandom));
        n_cmp++;
        if (act !== RST_VEC) begin
            n_bad++;
            $display("FAIL rst_active: got %h want %h", act, RST_VEC);
        end
    endtask

    task automatic test_random();
        logic r, l, e;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 255) != 0);
            l = ($urandom_range(0, 15) != 0);
            e = ($urandom_range(0, 31) != 0);
            tick(r, l, e, 30'($urandom));
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_datapath();
        test_lock_glitch();
        test_lock_loss();
        test_enable_drop();
        test_relock_sat();
        test_rst_in_active();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
